// File: rtl/ps2_pkg.sv
// ps2_pkg: shared receiver state type, data width and PS/2 frame bit positions.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    localparam int PS2_DATA_BITS = 8;
    localparam int START_POS     = 0;
    localparam int DATA_POS      = 1;
    localparam int PARITY_POS    = DATA_POS + PS2_DATA_BITS;
    localparam int STOP_POS      = PARITY_POS + 1;
    localparam int FRAME_BITS    = STOP_POS + 1;
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: synchronizes both PS/2 lines and flags falling edges of the PS/2 clock.
module ps2_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data
);
    logic [STAGES-1:0] c_sh, d_sh;
    logic c_prev;
    // Flops reset to the idle-high line level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c_sh   <= '1;
            d_sh   <= '1;
            c_prev <= 1'b1;
        end else begin
            c_sh   <= {c_sh[STAGES-2:0], ps2_clk};
            d_sh   <= {d_sh[STAGES-2:0], ps2_data};
            c_prev <= c_sh[STAGES-1];
        end
    end
    assign fall = c_prev & ~c_sh[STAGES-1];
    assign data = d_sh[STAGES-1];
endmodule

// File: rtl/ps2_byte_rx.sv
// ps2_byte_rx: PS/2 device-to-host byte receiver with parity/stop checking.
// Define PS2_RX_TIMEOUT_EN to build the watchdog that aborts stalled frames.
import ps2_pkg::*;
module ps2_byte_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       timeout_err
);
    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("ps2_byte_rx: SYNC_STAGES and TIMEOUT_CYCLES must be at least 2");
    end
    logic fall, bit_s, abort;
    state_t state;
    logic [2:0] cnt;
    logic [PS2_DATA_BITS-1:0] sh;
    logic par;
    ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .fall(fall), .data(bit_s)
    );
`ifdef PS2_RX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd;
    // The pulse is registered, so fire one count early to land TIMEOUT_CYCLES after the edge cycle.
    assign abort = state != IDLE && !fall && wd == WD_W'(TIMEOUT_CYCLES - 2);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) wd <= '0;
        else wd <= (fall || state == IDLE) ? '0 : wd + 1'b1;
    end
`else
    assign abort = 1'b0;
`endif
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= '0;
            sh          <= '0;
            par         <= 1'b0;
            byte_out    <= 8'h00;
            byte_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= abort;
            if (abort) state <= IDLE;
            else if (fall) begin
                case (state)
                    IDLE: if (!bit_s) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                    DATA: begin
                        sh  <= {bit_s, sh[PS2_DATA_BITS-1:1]};
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'(PS2_DATA_BITS - 1)) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= bit_s;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!bit_s) frame_err <= 1'b1;
                        else if (^{sh, par}) begin
                            byte_out   <= sh;
                            byte_valid <= 1'b1;
                        end else parity_err <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_byte_rx.sv
// tb_ps2_byte_rx: randomized PS/2 frames checked against a frame-level reference model.
import ps2_pkg::*;
module tb_ps2_byte_rx;
    localparam int SYNC = 2;
    localparam int TMO  = 100;
    localparam int HALF = 4;
    logic clk = 1'b0, resetn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] byte_out;
    logic byte_valid, parity_err, frame_err, timeout_err;
    int checks = 0, failures = 0, cyc = 0, last_fall = 0, prev_n = 0;
    logic [15:0] obs[$], exp_q[$];
    logic [7:0] exp_byte = 8'h00;

    ps2_byte_rx #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .byte_out(byte_out), .byte_valid(byte_valid), .parity_err(parity_err),
        .frame_err(frame_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Event code: kind in the upper byte (1 valid, 2 parity, 3 frame, 4 timeout), data in the lower.
    always @(negedge clk) begin
        int n;
        logic [7:0] kind;
        n = int'(byte_valid) + int'(parity_err) + int'(frame_err) + int'(timeout_err);
        if (n != 0) begin
            kind = byte_valid ? 8'd1 : parity_err ? 8'd2 : frame_err ? 8'd3 : 8'd4;
            chk("onehot", n, 1);
            chk("width", prev_n, 0);
            chk("latency", cyc - last_fall, kind == 8'd4 ? SYNC + TMO : SYNC + 1);
            obs.push_back({kind, byte_valid ? byte_out : 8'h00});
        end
        prev_n = n;
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[START_POS] = 1'b0;
        f[DATA_POS +: PS2_DATA_BITS] = d;
        f[PARITY_POS] = p;
        f[STOP_POS] = s;
        for (int i = 0; i < FRAME_BITS; i++) send_bit(f[i]);
        if (!s) exp_q.push_back(16'h0300);
        else if ((($countones(d) + int'(p)) % 2) == 1) begin
            exp_q.push_back({8'h01, d});
            exp_byte = d;
        end else exp_q.push_back(16'h0200);
    endtask

    task automatic check_events(input string tag);
        repeat (8) @(negedge clk);
        chk({tag, "_count"}, obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) chk({tag, "_event"}, obs[i], exp_q[i]);
        chk({tag, "_byte"}, byte_out, exp_byte);
        obs.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic p, s;
        repeat (5) @(negedge clk);
        chk("rst_byte", byte_out, 8'h00);
        chk("rst_pulses", {byte_valid, parity_err, frame_err, timeout_err}, 4'b0000);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b1);
        check_events("good_5a");
        send_frame(8'h08, 1'b1, 1'b1);
        check_events("bad_parity");
        send_frame(8'h33, 1'b1, 1'b0);
        check_events("bad_stop");
        send_frame(8'h01, 1'b0, 1'b1);
        check_events("good_01");
        send_frame(8'h08, 1'b0, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'h02, 1'b0, 1'b1);
        check_events("b2b");
        d = 8'h6C;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
`ifdef PS2_RX_TIMEOUT_EN
        exp_q.push_back(16'h0400);
        repeat (TMO + 50) @(negedge clk);
        check_events("timeout");
        send_frame(8'hFF, 1'b1, 1'b1);
        check_events("after_timeout");
`else
        repeat (3 * TMO) @(negedge clk);
        chk("stall_quiet", obs.size(), 0);
        for (int i = 4; i < 8; i++) send_bit(d[i]);
        send_bit(~^d);
        send_bit(1'b1);
        exp_q.push_back({8'h01, d});
        exp_byte = d;
        check_events("stall_resume");
`endif
        d = 8'hC3;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(d[i]);
        @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_byte", byte_out, 8'h00);
        resetn = 1'b1;
        exp_byte = 8'h00;
        check_events("midrst");
        send_frame(8'hA5, 1'b1, 1'b1);
        check_events("after_rst");
        for (int k = 0; k < 20; k++) begin
            d = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            s = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 2) == 0) send_bit(1'b1);
            send_frame(d, p, s);
            if ($urandom_range(0, 1) == 1) check_events("rand");
        end
        check_events("rand_end");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
